// File: rtl/wrr_grant_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin grant arbiter.
package arb_pkg;

    // Arbiter top-level state: no owner, or a transaction in flight.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Widest weight field eff_w accepts; callers zero-extend narrower weights.
    localparam int EFF_W_WIDTH = 16;

    // Effective weight: a zero weight still earns one grant per turn.
    function automatic logic [EFF_W_WIDTH-1:0] eff_w(input logic [EFF_W_WIDTH-1:0] w);
        return (w == '0) ? EFF_W_WIDTH'(1) : w;
    endfunction

endpackage

// File: rtl/wrr_grant_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    // Rotate so that bit 0 of req_rot corresponds to requester ptr.
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> ptr);

    // Priority-encode the rotated vector: lowest set bit wins.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found = 1'b1;
                off   = IDX_W'(k);
            end
        end
    end

    // Un-rotate: winner = (ptr + off) mod NUM_REQ.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            idx = IDX_W'(sum - (IDX_W+1)'(NUM_REQ));
        end else begin
            idx = IDX_W'(sum);
        end
    end

endmodule

// File: rtl/wrr_grant_arbiter.sv
// Weighted round-robin arbiter: grants one transaction-level owner at a time,
// lets each requester take up to its weight of consecutive grants, and tracks
// per-requester wait time with sticky starvation flags.
module wrr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4,   // must not exceed EFF_W_WIDTH
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 8,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
    input  logic                         done,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         gnt_valid,
    output logic [IDX_W-1:0]             gnt_id,
    output logic [NUM_REQ-1:0]           starve
);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WEIGHT_W-1:0]   cred_q, cred_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]      gnt_id_q, gnt_id_d;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  arb_event;
    logic [WEIGHT_W-1:0]   weight_arr [NUM_REQ];
    logic [EFF_W_WIDTH-1:0] win_eff_w;
    logic [WEIGHT_W-1:0]   turn_left;

    genvar gi;

    // Unpack the flat weight bus into one field per requester.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_weight
            assign weight_arr[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A new owner is chosen from IDLE on any request, or when the owner finishes
    // or silently drops its request.
    assign arb_event = (state_q == IDLE)  ? (|req)
                                          : (done || !req[gnt_id_q]);

    // Next-state, pointer/credit and grant decisions for the arbitration event.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cred_d    = cred_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        win_eff_w = eff_w(EFF_W_WIDTH'(weight_arr[pick_idx]));
        turn_left = '0;

        if (arb_event) begin
            if (!pick_found) begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end else begin
                state_d  = GRANT;
                gnt_d    = NUM_REQ'(1) << pick_idx;
                gnt_id_d = pick_idx;
                // Continue the current turn if it is loaded, else load a fresh one
                // from the winner's weight (sampled only here).
                if (pick_idx == rr_ptr_q && cred_q != '0) begin
                    turn_left = cred_q - 1'b1;
                end else begin
                    turn_left = WEIGHT_W'(win_eff_w - 1'b1);
                end
                if (turn_left == '0) begin
                    rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    cred_d   = '0;
                end else begin
                    rr_ptr_d = pick_idx;
                    cred_d   = turn_left;
                end
            end
        end
    end

    // Arbiter state registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cred_q   <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cred_q   <= cred_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    // Per-requester saturating wait counter and sticky starvation flag.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_wait
            logic [WAIT_W-1:0] wait_q, wait_d;
            logic              starve_q;

            // Clear while served or not asking; otherwise count up and saturate.
            always_comb begin
                wait_d = wait_q;
                if (gnt_q[gi] || !req[gi]) begin
                    wait_d = '0;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end

            // Register the counter; the flag latches once the threshold is reached.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wait_q   <= '0;
                    starve_q <= 1'b0;
                end else begin
                    wait_q <= wait_d;
                    if (wait_q >= WAIT_W'(MAX_WAIT)) begin
                        starve_q <= 1'b1;
                    end
                end
            end

            assign starve[gi] = starve_q;
        end
    endgenerate

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_wrr_grant_arbiter.sv
// Self-checking bench for wrr_grant_arbiter: directed scenarios with literal
// expectations plus a randomized run, all cross-checked every cycle against a
// behavioural model of the arbitration rules.
module tb_wrr_grant_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int MW = 8;
    localparam int WT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*WW-1:0] weight = '0;
    logic          done = 1'b0;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [1:0]    gnt_id;
    logic [N-1:0]  starve;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wrr_grant_arbiter #(
        .NUM_REQ  (N),
        .WEIGHT_W (WW),
        .MAX_WAIT (MW),
        .WAIT_W   (WT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .weight    (weight),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .starve    (starve)
    );

    // ---------------- behavioural model ----------------
    int       m_owner = -1;     // granted requester, -1 when nobody owns the resource
    int       m_ptr   = 0;
    int       m_cred  = 0;
    int       m_wait [N];
    bit [N-1:0] m_starve = '0;
    bit       cmp_en = 1'b0;

    task automatic model_step();
        int w, ew, c, idx;
        bit ev;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_cred = 0; m_starve = '0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            return;
        end
        for (int i = 0; i < N; i++) if (m_wait[i] >= MW) m_starve[i] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (m_owner == i || !req[i]) m_wait[i] = 0;
            else if (m_wait[i] < (1 << WT) - 1) m_wait[i] = m_wait[i] + 1;
        end
        ev = (m_owner < 0) ? (req != '0) : (done || !req[m_owner]);
        if (!ev) return;
        if (req == '0) begin
            m_owner = -1;
            return;
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (w < 0 && req[idx]) w = idx;
        end
        ew = int'(weight[w*WW +: WW]);
        if (ew == 0) ew = 1;
        c = (w == m_ptr && m_cred != 0) ? m_cred - 1 : ew - 1;
        if (c == 0) begin m_ptr = (w + 1) % N; m_cred = 0; end
        else        begin m_ptr = w;           m_cred = c; end
        m_owner = w;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input int act, input int expv);
        tests = tests + 1;
        if (act !== expv) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        int eg, ev, eid;
        @(negedge clk);
        if (cmp_en) begin
            eg  = (m_owner < 0) ? 0 : (1 << m_owner);
            ev  = (m_owner < 0) ? 0 : 1;
            eid = (m_owner < 0) ? 0 : m_owner;
            check("model_cycle", int'({gnt, gnt_valid, gnt_id, starve}),
                  (eg << 7) | (ev << 6) | (eid << 4) | int'(m_starve));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int act, input int expv);
        check(name, act, expv);
        $display("[TB] %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
    endtask

    int seq2 [5] = '{0, 1, 2, 3, 0};
    int seq3 [8] = '{0, 0, 0, 1, 2, 2, 3, 0};

    initial begin
        // Reset holds everything low even with all requests up.
        rst = 1'b1; req = 4'b1111; weight = {4'd1, 4'd1, 4'd1, 4'd1}; done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp_en = 1'b1;
            @(negedge clk);
            lit("rst_gnt", int'(gnt), 0);
            lit("rst_starve", int'(starve), 0);
        end
        tick(); rst = 1'b0;
        @(negedge clk); lit("rst_last_gnt", int'(gnt), 0);
        tick();
        @(negedge clk); lit("rst_first_gnt", int'(gnt), 1);

        // Equal weights, done every second cycle: plain rotation with no bubbles.
        do_reset(); weight = {4'd1, 4'd1, 4'd1, 4'd1}; req = 4'b1111; done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); done = 1'b0;
            @(negedge clk);
            lit("eq_id", int'(gnt_id), seq2[k]);
            lit("eq_valid", int'(gnt_valid), 1);
            tick(); done = 1'b1;
            @(negedge clk);
            lit("eq_id_hold", int'(gnt_id), seq2[k]);
        end

        // Weighted turns {3,1,2,1}, done every cycle.
        do_reset(); weight = {4'd1, 4'd2, 4'd1, 4'd3}; req = 4'b1111; done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            lit("wt_id", int'(gnt_id), seq3[k]);
        end

        // Zero weight behaves as one; wrap-around; implicit release by req drop.
        do_reset(); weight = {4'd1, 4'd1, 4'd0, 4'd1}; req = 4'b0110; done = 1'b0;
        tick();              @(negedge clk); lit("w0_first", int'(gnt), 4'b0010);
        tick(); done = 1'b1; @(negedge clk); lit("w0_hold", int'(gnt), 4'b0010);
        tick(); done = 1'b0; @(negedge clk); lit("w0_next", int'(gnt), 4'b0100);
        tick(); done = 1'b1; @(negedge clk); lit("w0_hold2", int'(gnt), 4'b0100);
        tick(); done = 1'b0; @(negedge clk); lit("w0_wrap", int'(gnt), 4'b0010);
        tick(); req = 4'b0100; @(negedge clk); lit("drop_hold", int'(gnt), 4'b0010);
        tick();              @(negedge clk); lit("drop_handoff", int'(gnt), 4'b0100);

        // Sole owner drops req without done: back to idle; stray done ignored.
        tick(); req = 4'b0000; @(negedge clk); lit("idle_hold", int'(gnt), 4'b0100);
        tick();              @(negedge clk); lit("idle_gnt", int'({gnt, gnt_valid, gnt_id}), 0);
        tick(); done = 1'b1; @(negedge clk); lit("idle_done_a", int'(gnt), 0);
        tick(); done = 1'b0; @(negedge clk); lit("idle_done_b", int'(gnt), 0);
        tick();              @(negedge clk); lit("idle_done_c", int'(gnt_valid), 0);

        // Starvation: requester 0 hogs the grant while requester 2 waits.
        do_reset(); weight = {4'd1, 4'd1, 4'd1, 4'd1}; req = 4'b0001; done = 1'b0;
        tick(); req = 4'b0101; @(negedge clk); lit("stv_owner", int'(gnt), 4'b0001);
        for (int k = 1; k <= 12; k++) begin
            tick();
            @(negedge clk);
            if (k == 8)  lit("stv_before", int'(starve), 0);
            if (k == 9)  lit("stv_set", int'(starve), 4'b0100);
            if (k == 12) lit("stv_still", int'(starve), 4'b0100);
        end
        tick(); done = 1'b1; @(negedge clk); lit("stv_hold", int'(gnt), 4'b0001);
        tick(); done = 1'b0; @(negedge clk); lit("stv_gnt2", int'(gnt), 4'b0100);
        lit("stv_sticky", int'(starve), 4'b0100);
        tick(); req = 4'b0000; @(negedge clk);
        tick();              @(negedge clk); lit("stv_after", int'(starve), 4'b0100);

        // Randomized traffic, weight changes and occasional resets.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            tick();
            if (k % 500 < 250) req = N'($urandom);
            else               req = N'($urandom & $urandom);
            done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) weight = (N*WW)'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        tick(); rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
